instr_encoder: RTL and testbench



---
 rtl/instr_fmt_pkg.sv | 65 ++++++
 rtl/imm_range_chk.sv | 50 +++++
 rtl/instr_encoder.sv | 158 +++++++++++++++
 tb/tb_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fmt_pkg.sv
// Shared definitions for the RV32I instruction encoder: field widths, major
// opcodes, instruction format classes, error codes, the request payload and
// the opcode-to-format classifier.
package instr_fmt_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned ERR_W = 2;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    localparam logic [ERR_W-1:0] ERR_OK    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_RANGE = 2'd1;
    localparam logic [ERR_W-1:0] ERR_ALIGN = 2'd2;
    localparam logic [ERR_W-1:0] ERR_OPC   = 2'd3;

    // Encode request payload as captured into stage 1
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
    } enc_req_t;

    // Map a major opcode onto its instruction format
    function automatic fmt_e classify(input logic [OPC_W-1:0] op);
        fmt_e f;
        case (op)
            OPC_OP:                                   f = FMT_R;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                f = FMT_S;
            OPC_BRANCH:                               f = FMT_B;
            OPC_LUI, OPC_AUIPC:                       f = FMT_U;
            OPC_JAL:                                  f = FMT_J;
            default:                                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational format classifier and immediate checker.
// Ports:
//   opcode_i  major opcode
//   imm_i     immediate (signed byte offset, or full value for U-type)
//   fmt_o     instruction format
//   err_o     error code; bad opcode > misaligned > out of range
module imm_range_chk
    import instr_fmt_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [XLEN-1:0]  imm_i,
    output fmt_e             fmt_o,
    output logic [ERR_W-1:0] err_o
);

    localparam logic signed [XLEN-1:0] IS_MIN = -32'sd2048;
    localparam logic signed [XLEN-1:0] IS_MAX = 32'sd2047;
    localparam logic signed [XLEN-1:0] B_MIN  = -32'sd4096;
    localparam logic signed [XLEN-1:0] B_MAX  = 32'sd4094;
    localparam logic signed [XLEN-1:0] J_MIN  = -32'sd1048576;
    localparam logic signed [XLEN-1:0] J_MAX  = 32'sd1048574;

    logic signed [XLEN-1:0] imm_s;
    assign imm_s = $signed(imm_i);

    // Alignment is tested before range so it wins on a tie
    always_comb begin
        fmt_o = classify(opcode_i);
        err_o = ERR_OK;
        case (fmt_o)
            FMT_I, FMT_S: begin
                if (imm_s < IS_MIN || imm_s > IS_MAX) err_o = ERR_RANGE;
            end
            FMT_B: begin
                if (imm_i[0])                              err_o = ERR_ALIGN;
                else if (imm_s < B_MIN || imm_s > B_MAX)   err_o = ERR_RANGE;
            end
            FMT_J: begin
                if (imm_i[0])                              err_o = ERR_ALIGN;
                else if (imm_s < J_MIN || imm_s > J_MAX)   err_o = ERR_RANGE;
            end
            FMT_U: begin
                if (imm_i[11:0] != 12'd0) err_o = ERR_ALIGN;
            end
            FMT_BAD: err_o = ERR_OPC;
            default: err_o = ERR_OK;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage elastic RV32I instruction encoder. Stage 1 registers the request
// with its format and error code; stage 2 registers the packed word, which is
// replaced by NOP_WORD whenever an error is reported.
// Optional macro ERR_COUNT_EN adds a 16-bit saturating count of error words
// transferred on the output.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       request handshake (in_ready is combinational)
//   in_opcode..in_imm       request fields
//   out_valid/out_ready     result handshake
//   out_instr, out_err      encoded word and error code
//   err_count               error transfer count (ERR_COUNT_EN only)
module instr_encoder
    import instr_fmt_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [F3_W-1:0]   in_funct3,
    input  logic [F7_W-1:0]   in_funct7,
    input  logic [XLEN-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [ERR_W-1:0]  out_err
`ifdef ERR_COUNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    logic             s1_valid_q, s1_valid_d;
    enc_req_t         s1_req_q, s1_req_d;
    fmt_e             s1_fmt_q, s1_fmt_d;
    logic [ERR_W-1:0] s1_err_q, s1_err_d;
    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  s2_instr_q, s2_instr_d;
    logic [ERR_W-1:0] s2_err_q, s2_err_d;

    enc_req_t         in_req_c;
    fmt_e             chk_fmt_c;
    logic [ERR_W-1:0] chk_err_c;
    logic             adv2_c;
    logic             accept_c;
    logic [XLEN-1:0]  pack_c;

    assign in_req_c = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                        funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    imm_range_chk u_chk (
        .opcode_i (in_opcode),
        .imm_i    (in_imm),
        .fmt_o    (chk_fmt_c),
        .err_o    (chk_err_c)
    );

    // Stage 2 frees when empty or draining; stage 1 frees when empty or moving on
    assign adv2_c   = !s2_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || adv2_c);
    assign accept_c = in_valid && in_ready;

    // Field packing for the entry held in stage 1
    always_comb begin
        pack_c = NOP_WORD;
        case (s1_fmt_q)
            FMT_R: pack_c = {s1_req_q.funct7, s1_req_q.rs2, s1_req_q.rs1,
                             s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
            FMT_I: pack_c = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3,
                             s1_req_q.rd, s1_req_q.opcode};
            FMT_S: pack_c = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1,
                             s1_req_q.funct3, s1_req_q.imm[4:0], s1_req_q.opcode};
            FMT_B: pack_c = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2,
                             s1_req_q.rs1, s1_req_q.funct3, s1_req_q.imm[4:1],
                             s1_req_q.imm[11], s1_req_q.opcode};
            FMT_U: pack_c = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
            FMT_J: pack_c = {s1_req_q.imm[20], s1_req_q.imm[10:1], s1_req_q.imm[11],
                             s1_req_q.imm[19:12], s1_req_q.rd, s1_req_q.opcode};
            default: pack_c = NOP_WORD;
        endcase
        if (s1_err_q != ERR_OK) pack_c = NOP_WORD;
    end

    // Next-state for both pipeline stages; payloads hold unless a new entry lands
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s1_fmt_d   = s1_fmt_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;

        if (in_ready) s1_valid_d = in_valid;
        if (accept_c) begin
            s1_req_d = in_req_c;
            s1_fmt_d = chk_fmt_c;
            s1_err_d = chk_err_c;
        end

        if (adv2_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pack_c;
                s2_err_d   = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s1_fmt_q   <= FMT_BAD;
            s1_err_q   <= ERR_OK;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= ERR_OK;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;

`ifdef ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating count of error words actually handed to the consumer
    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && out_ready && s2_err_q != ERR_OK && err_count_q != 16'hFFFF)
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_count_q <= 16'd0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, stall and
// reset sequences, and randomized traffic against a reference model.
module tb_instr_encoder;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } tb_req_t;

    typedef struct {
        tb_req_t     r;
        logic [31:0] instr;
        logic [1:0]  err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
`ifdef ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    instr_encoder dut (
`ifdef ERR_COUNT_EN
        .err_count (err_count),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    int          exp_errcnt = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_instr;
    logic [1:0]  prev_err;
    vec_t        tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic tb_req_t mkreq(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm);
        tb_req_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    function automatic vec_t mkvec(input tb_req_t r, input logic [31:0] instr, input logic [1:0] err);
        vec_t v;
        v.r = r; v.instr = instr; v.err = err;
        return v;
    endfunction

    // Reference encoder: format by opcode, checks by integer range, packing by shifts
    function automatic logic [33:0] ref_encode(input tb_req_t r);
        int          v;
        int          kind;
        logic [31:0] u, w, regs;
        logic [1:0]  e;
        v = int'($signed(r.imm));
        u = r.imm;
        case (r.op)
            7'h33:                      kind = 0;
            7'h03, 7'h13, 7'h67, 7'h73: kind = 1;
            7'h23:                      kind = 2;
            7'h63:                      kind = 3;
            7'h37, 7'h17:               kind = 4;
            7'h6F:                      kind = 5;
            default:                    kind = 6;
        endcase
        e = 2'd0;
        case (kind)
            1, 2: if (v < -2048 || v > 2047) e = 2'd1;
            3: begin
                if (u % 2 != 0) e = 2'd2;
                else if (v < -4096 || v > 4094) e = 2'd1;
            end
            5: begin
                if (u % 2 != 0) e = 2'd2;
                else if (v < -1048576 || v > 1048574) e = 2'd1;
            end
            4: if (u % 4096 != 0) e = 2'd2;
            6: e = 2'd3;
            default: e = 2'd0;
        endcase
        regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
        case (kind)
            0: w = (32'(r.f7) << 25) | regs | (32'(r.rd) << 7);
            1: w = ((u % 4096) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7);
            2: w = (((u >> 5) % 128) << 25) | regs | ((u % 32) << 7);
            3: w = (((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | regs
                 | (((u >> 1) % 16) << 8) | (((u >> 11) % 2) << 7);
            4: w = ((u / 4096) << 12) | (32'(r.rd) << 7);
            5: w = (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21) | (((u >> 11) % 2) << 20)
                 | (((u >> 12) % 256) << 12) | (32'(r.rd) << 7);
            default: w = 32'd0;
        endcase
        w = w | 32'(r.op);
        if (e != 2'd0) w = 32'h0000_0013;
        return {e, w};
    endfunction

    function automatic tb_req_t rand_req();
        logic [6:0]  ops[10];
        int          bnd[12];
        tb_req_t     r;
        int          m;
        ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        bnd = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                1048574, -1048576, 1048576, 32'h1234_5000};
        r.op  = ($urandom_range(0, 11) < 10) ? ops[$urandom_range(0, 9)] : 7'($urandom);
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.f3  = 3'($urandom);
        r.f7  = 7'($urandom);
        m = int'($urandom_range(0, 3));
        case (m)
            0: r.imm = $urandom;
            1: r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            2: r.imm = 32'(bnd[$urandom_range(0, 11)]);
            default: r.imm = $urandom & 32'hFFFF_F000;
        endcase
        return r;
    endfunction

    task automatic drive(input logic v, input tb_req_t r);
        in_valid  = v;
        in_opcode = r.op;
        in_rd     = r.rd;
        in_rs1    = r.rs1;
        in_rs2    = r.rs2;
        in_funct3 = r.f3;
        in_funct7 = r.f7;
        in_imm    = r.imm;
    endtask

    // One cycle of scoreboarded traffic; entered and left at a falling edge
    task automatic step(input logic v, input tb_req_t r, input logic ordy,
                        output logic acc, output logic rdy);
        logic [33:0] e;
        drive(v, r);
        out_ready = ordy;
        #1;
`ifdef ERR_COUNT_EN
        check("err_count", 32'(err_count), 32'(exp_errcnt));
`endif
        if (hold_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_instr", out_instr, prev_instr);
            check("stall_err", 32'(out_err), 32'(prev_err));
        end
        rdy = in_ready;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%08h expected no output", out_instr);
            end else begin
                e = exp_q.pop_front();
                check("out_instr", out_instr, e[31:0]);
                check("out_err", 32'(out_err), 32'(e[33:32]));
                if (out_err != 2'd0 && exp_errcnt < 65535) exp_errcnt++;
            end
        end
        hold_prev  = out_valid && !out_ready;
        prev_instr = out_instr;
        prev_err   = out_err;
        if (acc) exp_q.push_back(ref_encode(r));
        @(negedge clk);
    endtask

    // Single request with an always-ready consumer; checks latency and result
    task automatic run_vec(input vec_t t);
        int n;
        @(negedge clk);
        drive(1'b1, t.r);
        out_ready = 1'b1;
        #1 check("vec_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("vec_latency", 32'(n), 32'd2);
        check("vec_instr", out_instr, t.instr);
        check("vec_err", 32'(out_err), 32'(t.err));
        if (out_valid && out_err != 2'd0 && exp_errcnt < 65535) exp_errcnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        tb_req_t sreq[4];
        tb_req_t z;
        logic    acc, rdy;
        int      idx;

        z = '0;
        tbl[0]  = mkvec(mkreq(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), 32'hFFF1_0093, 2'd0);
        tbl[1]  = mkvec(mkreq(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8),        32'h0051_2423, 2'd0);
        tbl[2]  = mkvec(mkreq(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd2048),     32'h0000_0013, 2'd1);
        tbl[3]  = mkvec(mkreq(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC), 32'hFE00_0EE3, 2'd0);
        tbl[4]  = mkvec(mkreq(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3),        32'h0000_0013, 2'd2);
        tbl[5]  = mkvec(mkreq(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800),      32'h0010_00EF, 2'd0);
        tbl[6]  = mkvec(mkreq(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000), 32'h0000_0013, 2'd1);
        tbl[7]  = mkvec(mkreq(7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), 32'h1234_51B7, 2'd0);
        tbl[8]  = mkvec(mkreq(7'h0B, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd3),        32'h0000_0013, 2'd3);
        tbl[9]  = mkvec(mkreq(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF), 32'h4031_00B3, 2'd0);
        tbl[10] = mkvec(mkreq(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800), 32'h8000_0013, 2'd0);
        tbl[11] = mkvec(mkreq(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h2001),     32'h0000_0013, 2'd2);

        sreq[0] = mkreq(7'h13, 5'd4, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        sreq[1] = mkreq(7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2);
        sreq[2] = mkreq(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4000);
        sreq[3] = mkreq(7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);

        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, z);
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        #1 check("rel_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) run_vec(tbl[i]);
        @(negedge clk);
`ifdef ERR_COUNT_EN
        check("tbl_err_count", 32'(err_count), 32'(exp_errcnt));
`endif

        // Four back-to-back requests with the consumer stalled for 3 cycles
        hold_prev = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 30 && (idx < 4 || exp_q.size() > 0); cyc++) begin
            step(idx < 4, (idx < 4) ? sreq[idx] : z, cyc >= 3, acc, rdy);
            if (cyc < 2) check("stall_accept", 32'(acc), 32'd1);
            if (cyc == 2) check("stall_in_ready_low", 32'(rdy), 32'd0);
            if (acc) idx++;
        end
        check("stall_all_sent", 32'(idx), 32'd4);
        check("stall_all_out", 32'(exp_q.size()), 32'd0);

        // Fill both stages, then reset for one cycle
        step(1'b1, tbl[2].r, 1'b0, acc, rdy);
        step(1'b1, tbl[8].r, 1'b0, acc, rdy);
        #1 check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 check("in_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        exp_errcnt = 0;
        hold_prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, z, 1'b1, acc, rdy);
            check("flush_no_output", 32'(out_valid), 32'd0);
        end

        // Three error words after reset
        step(1'b1, tbl[2].r, 1'b1, acc, rdy);
        step(1'b1, tbl[4].r, 1'b1, acc, rdy);
        step(1'b1, tbl[8].r, 1'b1, acc, rdy);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0, z, 1'b1, acc, rdy);
        step(1'b0, z, 1'b1, acc, rdy);
        check("err3_drained", 32'(exp_q.size()), 32'd0);
`ifdef ERR_COUNT_EN
        check("err_count_3", 32'(err_count), 32'd3);
`endif

        // Random traffic with random backpressure
        for (int k = 0; k < 500; k++)
            step($urandom_range(0, 9) < 7, rand_req(), $urandom_range(0, 9) < 7, acc, rdy);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0, z, 1'b1, acc, rdy);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
